// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell plus borrow flop.
// Optional signed-overflow output guarded by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] sa, sb, sr;
   logic [WIDTH-1:0] sr_nxt;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             d, br_nxt;
   logic             load, step, fin;

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb, b_msb;
`endif

   // full-subtractor cell on the current LSBs and the running borrow
   always_comb begin
      d      = sa[0] ^ sb[0] ^ br;
      br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
      sr_nxt = {d, sr[WIDTH-1:1]};
   end

   // next-state and control strobes
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      fin       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt == LAST) begin
               fin       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // operand/result shift registers, borrow and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa  <= '0;
         sb  <= '0;
         sr  <= '0;
         br  <= 1'b0;
         cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= 1'b0;
         b_msb <= 1'b0;
`endif
      end else if (load) begin
         sa  <= a;
         sb  <= b;
         br  <= 1'b0;
         cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
`endif
      end else if (step) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         sr  <= sr_nxt;
         br  <= br_nxt;
         cnt <= cnt + 1'b1;
      end
   end

   // result registers: updated only on the completion edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf  <= 1'b0;
`endif
      end else begin
         done <= fin;
         if (fin) begin
            diff <= sr_nxt;
            bout <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= (a_msb != b_msb) & (sr_nxt[WIDTH-1] != a_msb);
`endif
         end
      end
   end

   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8).
// Vector table plus hand sequences for overlap, back-to-back and reset.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, bout;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int errors = 0;
   int checks = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] ed;
      logic         eb;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // wait for done (sampled 1 after each edge), return edges waited
   task automatic wait_done(output int n);
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (done) break;
      end
   endtask

   // one full operation from IDLE; start pulsed for one edge
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [W-1:0] ed, input logic eb,
                         input string nm);
      int n;
      int bcnt;
      @(negedge clk);
      a = ta;
      b = tb_;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 8'hAA;
      b = 8'h55;
      bcnt = busy ? 1 : 0;
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (done) break;
         if (busy) bcnt++;
      end
      chk({nm, " latency"}, n, W);
      chk({nm, " busy_cycles"}, bcnt, W);
      chk({nm, " diff"}, diff, ed);
      chk({nm, " bout"}, bout, eb);
      @(posedge clk);
      #1;
      chk({nm, " done_1cyc"}, done, 0);
   endtask

   vec_t vt[4];

   initial begin
      int n;
      logic stable;

      vt[0] = '{8'd200, 8'd55, 8'd145, 1'b0};
      vt[1] = '{8'd5,   8'd10, 8'hFB,  1'b1};
      vt[2] = '{8'd0,   8'd0,  8'd0,   1'b0};
      vt[3] = '{8'd1,   8'd255, 8'd2,  1'b1};

      #12;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst diff", diff, 0);
      chk("rst bout", bout, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++)
         run_op(vt[i].va, vt[i].vb, vt[i].ed, vt[i].eb,
                $sformatf("vec%0d", i));

`ifdef SERIAL_SUB_OVF_EN
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, "ovf_a");
      chk("ovf set", ovf, 1);
      run_op(8'h10, 8'h01, 8'h0F, 1'b0, "ovf_b");
      chk("ovf clr", ovf, 0);
`endif

      // start re-pulsed during an operation must be ignored
      @(negedge clk);
      a = 8'd9;
      b = 8'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a = 8'd1;
      b = 8'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n);
      chk("ovl latency", n, W - 3);
      chk("ovl diff", diff, 6);
      chk("ovl bout", bout, 0);
      n = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done || busy) n++;
      end
      chk("ovl no_second", n, 0);

      // back-to-back with start held high
      @(negedge clk);
      a = 8'd100;
      b = 8'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      a = 8'd7;
      b = 8'd9;
      wait_done(n);
      chk("b2b lat1", n, W);
      chk("b2b diff1", diff, 99);
      chk("b2b bout1", bout, 0);
      stable = 1'b1;
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (done) break;
         if (diff !== 8'd99) stable = 1'b0;
      end
      start = 1'b0;
      chk("b2b gap", n, W + 1);
      chk("b2b stable", stable, 1);
      chk("b2b diff2", diff, 254);
      chk("b2b bout2", bout, 1);
      @(posedge clk);
      #1;
      chk("b2b done_1cyc", done, 0);

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      a = 8'd200;
      b = 8'd55;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst busy", busy, 0);
      chk("mrst done", done, 0);
      chk("mrst diff", diff, 0);
      chk("mrst bout", bout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done || busy) n++;
      end
      chk("mrst no_done", n, 0);
      run_op(8'd5, 8'd10, 8'hFB, 1'b1, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
